// File: rtl/dm_arb_pkg.sv
// rtl/dm_arb_pkg.sv - shared types and constants for the data-memory arbiter
package dm_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } mid_e;

    localparam logic [3:0] WEB_NONE = 4'b1111;

endpackage

// File: rtl/dm_arb_if.sv
// rtl/dm_arb_if.sv - one master's request/ack port into the data-memory arbiter
interface dm_arb_if #(
    parameter int AW = 14
);
    logic          req;
    logic [3:0]    web;
    logic [AW+1:0] addr;
    logic [31:0]   wdata;
    logic          ack;
    logic [31:0]   rdata;

    modport master (output req, web, addr, wdata, input ack, rdata);
    modport slave  (input req, web, addr, wdata, output ack, rdata);
endinterface

// File: rtl/dm_arb_prio.sv
// rtl/dm_arb_prio.sv - winner select with an M0 streak limit that protects M1
module dm_arb_prio
    import dm_arb_pkg::*;
#(
    parameter int MAX_STREAK = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sample_i,
    input  logic m0_req_i,
    input  logic m1_req_i,
    output logic grant_o,
    output mid_e winner_o
);

    localparam int SW = $clog2(MAX_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);

    logic [SW-1:0] streak_q, streak_d;

    always_comb begin
        grant_o  = sample_i && (m0_req_i || m1_req_i);
        winner_o = (m0_req_i && !(m1_req_i && streak_q == STREAK_MAX)) ? M0 : M1;
        streak_d = streak_q;
        // Streak only counts M0 wins that actually made M1 wait.
        if (sample_i) begin
            if (!m1_req_i) begin
                streak_d = '0;
            end else if (winner_o == M1) begin
                streak_d = '0;
            end else if (streak_q != STREAK_MAX) begin
                streak_d = streak_q + SW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - two-master single-port data-memory arbiter, 3 cycles per access
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int MAX_STREAK = 4,
    parameter int AW         = 14
) (
    input  logic          clk,
    input  logic          rst_n,
    dm_arb_if.slave       m0,
    dm_arb_if.slave       m1,
    output logic          dm_ceb,
    output logic [3:0]    dm_web,
    output logic [AW-1:0] dm_addr,
    output logic [31:0]   dm_di,
    input  logic [31:0]   dm_do,
    output logic          busy
);

    state_e        state_q, state_d;
    mid_e          win_q, win_d;
    logic [3:0]    web_q, web_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          grant;
    mid_e          winner;

    // Byte lanes are chosen by web alone, so the low address bits never matter.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{m0.addr[1:0], m1.addr[1:0]};

    dm_arb_prio #(.MAX_STREAK(MAX_STREAK)) u_prio (
        .clk      (clk),
        .rst_n    (rst_n),
        .sample_i (state_q == IDLE),
        .m0_req_i (m0.req),
        .m1_req_i (m1.req),
        .grant_o  (grant),
        .winner_o (winner)
    );

    always_comb begin
        state_d  = state_q;
        win_d    = win_q;
        web_d    = web_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        dm_ceb   = 1'b1;
        dm_web   = WEB_NONE;
        m0.ack   = 1'b0;
        m1.ack   = 1'b0;
        m0.rdata = '0;
        m1.rdata = '0;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d = ISSUE;
                    win_d   = winner;
                    if (winner == M0) begin
                        web_d   = m0.web;
                        addr_d  = m0.addr[AW+1:2];
                        wdata_d = m0.wdata;
                    end else begin
                        web_d   = m1.web;
                        addr_d  = m1.addr[AW+1:2];
                        wdata_d = m1.wdata;
                    end
                end
            end
            ISSUE: begin
                dm_ceb  = 1'b0;
                dm_web  = web_q;
                state_d = RESP;
            end
            RESP: begin
                if (win_q == M0) begin
                    m0.ack   = 1'b1;
                    m0.rdata = dm_do;
                end else begin
                    m1.ack   = 1'b1;
                    m1.rdata = dm_do;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign dm_addr = addr_q;
    assign dm_di   = wdata_q;
    assign busy    = (state_q != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            win_q   <= M0;
            web_q   <= WEB_NONE;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            web_q   <= web_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 Parameter MAX_STREAK, default 4: consecutive M0 grants allowed while M1 waits.
REQ-002 Parameter AW, default 14: data-memory word-address width.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  sole clock, rising-edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 m0_req  in  1  CPU (M0) access request; held high until m0_ack.
REQ-007 m0_web  in  4  M0 per-byte write enable, active-low; 4'b1111 means read.
REQ-008 m0_addr  in  AW+2  M0 byte address.
REQ-009 m0_wdata  in  32  M0 lane-replicated store data.
REQ-010 m0_ack  out  1  M0 access complete, one-cycle pulse.
REQ-011 m0_rdata  out  32  M0 read data, valid while m0_ack=1.
REQ-012 m1_req, m1_web, m1_addr, m1_wdata, m1_ack, m1_rdata: same widths and meaning for the second master (M1).
REQ-013 dm_ceb  out  1  data-memory chip enable, active-low.
REQ-014 dm_web  out  4  data-memory byte write enable, active-low.
REQ-015 dm_addr  out  AW  data-memory word address.
REQ-016 dm_di  out  32  data-memory write data.
REQ-017 dm_do  in  32  data-memory read data, valid one cycle after the dm_ceb=0 cycle.
REQ-018 busy  out  1  high in any state other than IDLE.

Function
REQ-019 FSM states are IDLE, ISSUE and RESP; each transition takes exactly one clock.
REQ-020 In IDLE with no request, the FSM stays in IDLE; with any request, it latches the winner's web, addr and wdata plus a winner-ID bit and moves to ISSUE.
REQ-021 In ISSUE: dm_ceb=0, dm_web=latched web, dm_addr=latched addr[AW+1:2], dm_di=latched wdata; next state RESP.
REQ-022 In RESP: ack of the winner only =1, its rdata=dm_do, dm_ceb=1, dm_web=4'b1111; next state IDLE.
REQ-023 Outside ISSUE: dm_ceb=1 and dm_web=4'b1111; dm_addr and dm_di hold their last latched values.
REQ-024 Latency: a request sampled at IDLE edge E is acknowledged in the cycle after E+1; minimum spacing is 3 cycles per access, with one IDLE cycle between accesses.
REQ-025 Arbitration, both requesting: M0 wins unless streak==MAX_STREAK, in which case M1 wins.
REQ-026 Arbitration, single requester: that requester wins.
REQ-027 streak counter, width ceil(log2(MAX_STREAK+1)): incremented on an M0 grant while m1_req=1; cleared on an M1 grant or in any IDLE cycle with m1_req=0; saturates at MAX_STREAK.
REQ-028 Requests are sampled only in IDLE; req or field changes during ISSUE/RESP have no effect because the command is latched.
REQ-029 A request dropped before its ack is a protocol violation; the latched access still completes and the ack is still pulsed.
REQ-030 The non-winner's ack=0 and its rdata=32'b0 at all times it is not acknowledged.
REQ-031 Address bits [1:0] are ignored; lane selection is carried entirely by web.
REQ-032 A write access also pulses ack; its rdata is don't-care.

Reset
REQ-033 On rst_n=0, asynchronously: state=IDLE, dm_ceb=1, dm_web=4'b1111, dm_addr=0, dm_di=0, both acks=0, busy=0, streak=0, winner-ID=M0.
REQ-034 Reset asserted during ISSUE or RESP aborts the access with no ack; after rst_n rises, the first access begins from IDLE.

Structure
REQ-035 Shared package dm_arb_pkg holds: the state enum (IDLE, ISSUE, RESP), WEB_NONE=4'b1111, and the master-ID enum (M0, M1).
REQ-036 One sub-module, dm_arb_prio, contains the winner select and the streak counter; the FSM and command registers stay in dm_arbiter.

Verification
REQ-037 Single read: M0 read of addr 0x0010 while memory returns 0xDEADBEEF -> dm_ceb=0 with dm_addr=0x004 exactly one cycle after sampling; m0_ack=1 and m0_rdata=0xDEADBEEF the next cycle; m1_ack=0 throughout.
REQ-038 Byte store: M1 with web=4'b1011, addr=0x0022, wdata=0x5A5A5A5A -> one ISSUE cycle with dm_web=4'b1011, dm_addr=0x008, dm_di=0x5A5A5A5A; then m1_ack pulses once.
REQ-039 Tie: both masters request in the same IDLE cycle with streak=0 -> M0 is served first and M1 is served on the next IDLE.
REQ-040 Starvation guard: M0 and M1 both request continuously, MAX_STREAK=4 -> grant order M0,M0,M0,M0,M1,M0...; streak reads 0 after the M1 grant.
REQ-041 Reset mid-access: rst_n driven low during ISSUE -> dm_ceb=1 immediately, no ack is produced, state=IDLE, and a post-reset M0 read completes normally.
REQ-042 Request change after latch: m0_addr changed during ISSUE -> dm_addr still shows the originally sampled word address.
